// File: rtl/jtag_dr_sel_ctrl.sv
// JTAG data-register selector: latches a one-hot select at Update-IR and gates TAP strobes to it.
// Optional build macro JTAG_DR_LEN_CHECK_EN suppresses updates whose shift length is wrong.
module jtag_dr_sel_ctrl #(
    parameter int NUM_REGS  = 4,
    parameter int IR_WIDTH  = 5,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          tck_i,
    input  logic                          trst_ni,
    input  logic                          test_logic_reset_i,
    input  logic                          capture_dr_i,
    input  logic                          shift_dr_i,
    input  logic                          update_dr_i,
    input  logic                          update_ir_i,
    input  logic [IR_WIDTH-1:0]           ir_i,
    input  logic [NUM_REGS*IR_WIDTH-1:0]  reg_opcode_i,
    input  logic [NUM_REGS*CNT_WIDTH-1:0] reg_len_i,
    input  logic                          enable_i,
    output logic [NUM_REGS-1:0]           reg_sel_o,
    output logic [NUM_REGS-1:0]           reg_capture_o,
    output logic [NUM_REGS-1:0]           reg_shift_o,
    output logic [NUM_REGS-1:0]           reg_update_o,
    output logic                          update_enable_o,
    output logic [CNT_WIDTH-1:0]          shift_cnt_o,
    output logic                          len_err_o
);

    logic [NUM_REGS-1:0]  sel_q;
    logic [NUM_REGS-1:0]  dec_sel;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 any_sel;
    logic                 upd_ok;
    logic                 err_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Scan from the top down so the lowest matching index is the one that sticks.
    always_comb begin
        dec_sel = '0;
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            if (reg_opcode_i[k*IR_WIDTH +: IR_WIDTH] == ir_i) begin
                dec_sel    = '0;
                dec_sel[k] = 1'b1;
            end
        end
    end

    assign any_sel = |sel_q;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            sel_q <= '0;
        end else if (test_logic_reset_i) begin
            sel_q <= '0;
        end else if (update_ir_i) begin
            sel_q <= dec_sel;
        end
    end

    // Capture wins over a simultaneous shift; counter only moves while a register is selected.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            cnt_q <= '0;
        end else if (test_logic_reset_i) begin
            cnt_q <= '0;
        end else if (any_sel) begin
            if (capture_dr_i) begin
                cnt_q <= '0;
            end else if (shift_dr_i) begin
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

`ifdef JTAG_DR_LEN_CHECK_EN
    logic [CNT_WIDTH-1:0] sel_len;

    always_comb begin
        sel_len = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel_q[k]) begin
                sel_len = reg_len_i[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    assign upd_ok = (cnt_q == sel_len);

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            err_q <= 1'b0;
        end else if (test_logic_reset_i) begin
            err_q <= 1'b0;
        end else if (any_sel && capture_dr_i) begin
            err_q <= 1'b0;
        end else if (any_sel && update_dr_i && !upd_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    // Length port is kept for interface stability but carries no meaning in this build.
    logic unused_len;
    assign unused_len = ^reg_len_i;
    assign upd_ok     = 1'b1;
    assign err_q      = 1'b0;
`endif

    assign reg_sel_o       = sel_q;
    assign reg_capture_o   = sel_q & {NUM_REGS{capture_dr_i}};
    assign reg_shift_o     = sel_q & {NUM_REGS{shift_dr_i}};
    assign reg_update_o    = sel_q & {NUM_REGS{update_dr_i & upd_ok}};
    assign update_enable_o = enable_i & update_dr_i & upd_ok & any_sel;
    assign shift_cnt_o     = cnt_q;
    assign len_err_o       = err_q;

endmodule

// File: tb/tb_jtag_dr_sel_ctrl.sv
// Directed bench for jtag_dr_sel_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_jtag_dr_sel_ctrl;

    localparam int NR = 4;
    localparam int IW = 5;
    localparam int CW = 8;

    logic           tck = 1'b0;
    logic           trst_n;
    logic           tlr, cap, sh, upd, uir, en;
    logic [IW-1:0]  ir;
    logic [NR*IW-1:0] opc;
    logic [NR*CW-1:0] lens;
    logic [NR-1:0]  sel_o, cap_o, sh_o, upd_o;
    logic           ue_o;
    logic [CW-1:0]  cnt_o;
    logic           err_o;

    int tests = 0;
    int fails = 0;

    always #5 tck = ~tck;

    jtag_dr_sel_ctrl #(.NUM_REGS(NR), .IR_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
        .capture_dr_i(cap), .shift_dr_i(sh), .update_dr_i(upd), .update_ir_i(uir),
        .ir_i(ir), .reg_opcode_i(opc), .reg_len_i(lens), .enable_i(en),
        .reg_sel_o(sel_o), .reg_capture_o(cap_o), .reg_shift_o(sh_o), .reg_update_o(upd_o),
        .update_enable_o(ue_o), .shift_cnt_o(cnt_o), .len_err_o(err_o)
    );

    typedef struct packed {
        logic          tlr, cap, sh, upd, uir, en;
        logic [IW-1:0] ir;
        logic [NR-1:0] e_sel, e_cap, e_sh, e_upd;
        logic          e_ue;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are then sampled mid-low-phase.
    task automatic drive(input logic t, c, s, u, ui, e, input logic [IW-1:0] i);
        @(negedge tck);
        tlr = t; cap = c; sh = s; upd = u; uir = ui; en = e; ir = i;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic select_reg(input logic [IW-1:0] i);
        drive(0, 0, 0, 0, 1, 0, i);
        idle();
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_sel"}, 32'(sel_o), 0);
        chk({nm, "_cap"}, 32'(cap_o), 0);
        chk({nm, "_sh"},  32'(sh_o), 0);
        chk({nm, "_upd"}, 32'(upd_o), 0);
        chk({nm, "_ue"},  32'(ue_o), 0);
        chk({nm, "_cnt"}, 32'(cnt_o), 0);
        chk({nm, "_err"}, 32'(err_o), 0);
    endtask

    initial begin
        opc  = {5'h0B, 5'h0A, 5'h09, 5'h08};
        lens = {8'd0, 8'd3, 8'd0, 8'd0};
        tlr = 0; cap = 0; sh = 0; upd = 0; uir = 0; en = 0; ir = '0;

        // Reset held while TAP inputs toggle, including an Update-IR that would select reg 2.
        trst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1, 1'b1, 5'h0A);
            chk_quiet($sformatf("rst%0d", i));
        end
        @(negedge tck);
        trst_n = 1'b1;
        tlr = 0; cap = 0; sh = 0; upd = 0; uir = 0; en = 0; ir = '0;

        //          tlr cap sh upd uir en  ir      sel    cap    sh     upd    ue  cnt
        vt[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd0};
        vt[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'h0A, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd0};
        vt[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h4,4'h0,4'h0,4'h0,1'b0,8'd0};
        vt[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h4,4'h4,4'h0,4'h0,1'b0,8'd0};
        vt[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'h00, 4'h4,4'h0,4'h4,4'h0,1'b0,8'd0};
        vt[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'h00, 4'h4,4'h0,4'h4,4'h0,1'b0,8'd1};
        vt[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'h00, 4'h4,4'h0,4'h4,4'h0,1'b0,8'd2};
        vt[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h4,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'h00, 4'h4,4'h0,4'h0,4'h4,1'b1,8'd3};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'h00, 4'h4,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'h1F, 4'h4,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'h00, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'h00, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[15] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'h09, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h2,4'h0,4'h0,4'h0,1'b0,8'd3};
        vt[17] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'h00, 4'h2,4'h2,4'h2,4'h0,1'b0,8'd3};
        vt[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h2,4'h0,4'h0,4'h0,1'b0,8'd0};
        vt[19] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,5'h00, 4'h2,4'h0,4'h2,4'h0,1'b0,8'd0};
        vt[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'h00, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd0};
        vt[21] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,5'h00, 4'h0,4'h0,4'h0,4'h0,1'b0,8'd0};

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].tlr, vt[i].cap, vt[i].sh, vt[i].upd, vt[i].uir, vt[i].en, vt[i].ir);
            chk($sformatf("v%0d_sel", i), 32'(sel_o), 32'(vt[i].e_sel));
            chk($sformatf("v%0d_cap", i), 32'(cap_o), 32'(vt[i].e_cap));
            chk($sformatf("v%0d_sh", i),  32'(sh_o),  32'(vt[i].e_sh));
            chk($sformatf("v%0d_upd", i), 32'(upd_o), 32'(vt[i].e_upd));
            chk($sformatf("v%0d_ue", i),  32'(ue_o),  32'(vt[i].e_ue));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_o), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d_err", i), 32'(err_o), 0);
        end

        // Full 37-bit scan on reg 2 with the global enable low.
        lens = {8'd0, 8'd37, 8'd0, 8'd0};
        select_reg(5'h0A);
        chk("scan_sel", 32'(sel_o), 32'h4);
        drive(0, 1, 0, 0, 0, 0, '0);
        chk("scan_cap", 32'(cap_o), 32'h4);
        for (int i = 0; i < 37; i++) begin
            drive(0, 0, 1, 0, 0, 0, '0);
            chk($sformatf("scan_sh%0d", i), 32'(sh_o), 32'h4);
        end
        drive(0, 0, 0, 1, 0, 0, '0);
        chk("scan_cnt", 32'(cnt_o), 37);
        chk("scan_upd", 32'(upd_o), 32'h4);
        chk("scan_ue_dis", 32'(ue_o), 0);
        idle();
        chk("scan_upd_1cyc", 32'(upd_o), 0);

        // Saturation after 300 shifts, then capture clears.
        drive(0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 300; i++) drive(0, 0, 1, 0, 0, 0, '0);
        idle();
        chk("sat_cnt", 32'(cnt_o), 255);
        drive(0, 1, 0, 0, 0, 0, '0);
        idle();
        chk("sat_clr", 32'(cnt_o), 0);

        // Short 36-bit scan against an expected length of 37.
        for (int i = 0; i < 36; i++) drive(0, 0, 1, 0, 0, 0, '0);
        drive(0, 0, 0, 1, 0, 1, '0);
        chk("len36_cnt", 32'(cnt_o), 36);
`ifdef JTAG_DR_LEN_CHECK_EN
        chk("len36_upd", 32'(upd_o), 0);
        chk("len36_ue", 32'(ue_o), 0);
        idle();
        chk("len36_err", 32'(err_o), 1);
`else
        chk("len36_upd", 32'(upd_o), 32'h4);
        chk("len36_ue", 32'(ue_o), 1);
        idle();
        chk("len36_err", 32'(err_o), 0);
`endif
        drive(0, 1, 0, 0, 0, 0, '0);
        idle();
        chk("len_err_clr", 32'(err_o), 0);
        for (int i = 0; i < 37; i++) drive(0, 0, 1, 0, 0, 0, '0);
        drive(0, 0, 0, 1, 0, 1, '0);
        chk("len37_upd", 32'(upd_o), 32'h4);
        chk("len37_ue", 32'(ue_o), 1);
        idle();
        chk("len37_err", 32'(err_o), 0);

        // Duplicate opcode 0x09 in slots 1 and 3: lowest index wins.
        opc = {5'h09, 5'h0A, 5'h09, 5'h08};
        select_reg(5'h09);
        chk("dup_sel", 32'(sel_o), 32'h2);
        opc = {5'h0B, 5'h0A, 5'h09, 5'h08};

        // Test-Logic-Reset in the middle of a scan at count 10.
        select_reg(5'h0A);
        drive(0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0, 0, '0);
        drive(1, 0, 1, 0, 0, 0, '0);
        chk("tlr_cnt_before", 32'(cnt_o), 10);
        idle();
        chk("tlr_sel", 32'(sel_o), 0);
        chk("tlr_cnt", 32'(cnt_o), 0);
        drive(0, 0, 0, 1, 0, 1, '0);
        chk("tlr_upd", 32'(upd_o), 0);
        chk("tlr_ue", 32'(ue_o), 0);

        // Asynchronous reset dropping in the middle of Shift-DR.
        select_reg(5'h0A);
        drive(0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0, '0);
        chk("arst_pre_sh", 32'(sh_o), 32'h4);
        trst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel_o), 0);
        chk("arst_sh", 32'(sh_o), 0);
        chk("arst_cnt", 32'(cnt_o), 0);
        @(negedge tck);
        trst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 1, '0);
        chk("arst_upd", 32'(upd_o), 0);
        chk("arst_ue", 32'(ue_o), 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtag_dr_sel_ctrl.md
Name: jtag_dr_sel_ctrl

Overview:
Parametrised JTAG data-register selector and strobe generator for NUM_REGS user data registers.
- Latches a one-hot register select at Update-IR by matching the IR against per-register opcodes.
- Gates TAP capture/shift/update strobes to the selected register.
- Counts shifted bits per DR scan.
- Optionally suppresses updates whose shift length is wrong.
- Sits between the TAP controller and the DR bank (AXI, bbmux, clock-gate, config registers, and any added ones).

Parameters:
NUM_REGS, 4, number of selectable data registers (1..16)
IR_WIDTH, 5, instruction register width
CNT_WIDTH, 8, shift counter width; counter saturates at 2^CNT_WIDTH-1

Ports:
tck_i  in  1  TAP clock; all state on rising edge
trst_ni  in  1  asynchronous active-low reset
test_logic_reset_i  in  1  TAP in Test-Logic-Reset; synchronous clear of select/counter/error
capture_dr_i  in  1  TAP Capture-DR strobe
shift_dr_i  in  1  TAP Shift-DR strobe
update_dr_i  in  1  TAP Update-DR strobe
update_ir_i  in  1  TAP Update-IR strobe
ir_i  in  IR_WIDTH  current instruction register value
reg_opcode_i  in  NUM_REGS*IR_WIDTH  packed opcode per register; slice k = register k
reg_len_i  in  NUM_REGS*CNT_WIDTH  packed expected DR length per register (used only with feature)
enable_i  in  1  global update enable
reg_sel_o  out  NUM_REGS  registered one-hot select (all-zero = bypass)
reg_capture_o  out  NUM_REGS  reg_sel_o[k] & capture_dr_i
reg_shift_o  out  NUM_REGS  reg_sel_o[k] & shift_dr_i
reg_update_o  out  NUM_REGS  reg_sel_o[k] & update_dr_i & upd_ok
update_enable_o  out  1  enable_i & update_dr_i & upd_ok & (|reg_sel_o)
shift_cnt_o  out  CNT_WIDTH  bits shifted in the current DR scan
len_err_o  out  1  sticky length-mismatch flag

Behaviour:
- Reset (trst_ni=0, async): sel_q=0, cnt_q=0, err_q=0. All strobe outputs, update_enable_o, shift_cnt_o and len_err_o are 0.
- Select decode, registered:
  - On update_ir_i, sel_q <= one-hot of the lowest k with reg_opcode_i[k]==ir_i.
  - No match -> sel_q=0 (bypass).
  - Duplicate opcodes: lowest index wins; only one bit is ever set.
- Select latency: the new select is visible the cycle after update_ir_i. Strobes in the update_ir_i cycle use the old sel_q.
- test_logic_reset_i: sel_q, cnt_q, err_q <= 0 next edge. Takes priority over all other inputs.
- Strobes are combinational (zero latency) from the TAP inputs and sel_q.
- Shift counter:
  - capture_dr_i with any select -> cnt_q <= 0.
  - shift_dr_i with any select -> cnt_q <= cnt_q+1, saturating at all-ones (no wrap).
  - With sel_q=0 the counter holds.
- Simultaneous capture_dr_i & shift_dr_i (illegal TAP sequence): capture wins, cnt_q <= 0.
- upd_ok = 1 when the feature is compiled out.
- update_dr_i with sel_q=0: no reg_update_o bit set and update_enable_o=0.
- Mid-scan reset (trst_ni falling during Shift-DR): all outputs 0 immediately; a subsequent update_dr_i has no effect until a new Update-IR selects a register.

Optional Feature:
JTAG_DR_LEN_CHECK_EN
- Defined:
  - upd_ok = (cnt_q == reg_len_i slice of the selected register).
  - An update_dr_i with a selected register and upd_ok=0 suppresses reg_update_o and update_enable_o, and sets err_q <= 1.
  - err_q clears on capture_dr_i (selected register) or test_logic_reset_i.
  - len_err_o = err_q.
- Undefined: upd_ok=1; err_q held at 0; len_err_o=0; reg_len_i ignored (port kept for a stable interface).

Test Plan:
- Reset: trst_ni=0 with all TAP inputs toggling -> reg_sel_o=0, every strobe 0, shift_cnt_o=0, len_err_o=0.
- Decode: opcodes {0x08,0x09,0x0A,0x0B}, ir_i=0x0A, update_ir_i pulse -> reg_sel_o=4'b0100 next cycle. ir_i=0x1F -> 4'b0000. Duplicate 0x09 in slots 1 and 3 -> 4'b0010.
- Scan: select reg 2, capture 1 cycle, shift 37 cycles, update -> reg_capture_o[2], reg_shift_o[2]x37, reg_update_o[2] each 1 cycle; shift_cnt_o=37. With enable_i=0, update_enable_o stays 0.
- Saturation: CNT_WIDTH=8, shift 300 cycles -> shift_cnt_o=255. Then capture -> 0.
- Length check (macro defined): reg_len=37; shift 36 then update -> reg_update_o=0, len_err_o=1. Next capture -> len_err_o=0; shift 37, update -> reg_update_o[2]=1. Macro undefined: 36-bit scan updates, len_err_o=0.
- test_logic_reset_i mid-shift at count 10 -> reg_sel_o=0, shift_cnt_o=0 next cycle; following update_dr_i yields no strobes.
